// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per CALC cycle (shift-add / restoring divide).
// Define MULDIV_DIV_EN to build the divider; without it, op[2]=1 ops complete at once with illegal=1.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic            neg_q, neg_d, low_q, low_d;
    logic [XLEN-1:0] result_d;
    logic            illegal_d;
`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic            div_q, div_d, rem_q, rem_d;
    logic [XLEN:0]   div_sh;
    logic [XLEN-1:0] div_diff, div_hi, div_lo, quo_s, rem_s;
    logic            div_ge;
`endif

    // Start-cycle operand decode: signedness and magnitudes
    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    always_comb begin
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = a_signed & a[XLEN-1];
        sb       = b_signed & b[XLEN-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
    end

    // One iteration step plus the sign-corrected final value of the last step
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo, step_hi, step_lo, final_res;
    logic [PW-1:0]   prod, prod_s;
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        prod      = {mul_hi, mul_lo};
        prod_s    = neg_q ? -prod : prod;
        step_hi   = mul_hi;
        step_lo   = mul_lo;
        final_res = low_q ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
`ifdef MULDIV_DIV_EN
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = div_sh >= {1'b0, opnd_q};
        div_diff = div_sh[XLEN-1:0] - opnd_q;
        div_hi   = div_ge ? div_diff : div_sh[XLEN-1:0];
        div_lo   = {lo_q[XLEN-2:0], div_ge};
        quo_s    = neg_q ? -div_lo : div_lo;
        rem_s    = neg_q ? -div_hi : div_hi;
        if (div_q) begin
            step_hi   = div_hi;
            step_lo   = div_lo;
            final_res = rem_q ? rem_s : quo_s;
        end
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        low_d     = low_q;
        result_d  = result;
        illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d     = div_q;
        rem_d     = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    hi_d    = '0;
                    low_d   = (op == 3'b000);
                    neg_d   = (op == 3'b110) ? sa : (sa ^ sb);
`ifdef MULDIV_DIV_EN
                    div_d   = op[2];
                    rem_d   = op[1];
                    opnd_d  = op[2] ? mag_b : mag_a;
                    lo_d    = op[2] ? mag_a : mag_b;
                    if (op[2] && (b == '0)) begin
                        state_d  = DONE;
                        result_d = op[1] ? a : '1;
                    end else if (op[2] && !op[0] && (a == MIN_NEG) && (b == '1)) begin
                        state_d  = DONE;
                        result_d = op[1] ? '0 : a;
                    end
`else
                    opnd_d  = mag_a;
                    lo_d    = mag_b;
                    if (op[2]) begin
                        state_d   = DONE;
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = step_hi;
                lo_d  = step_lo;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d  = DONE;
                    result_d = final_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            low_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            rem_q   <= 1'b0;
`endif
            result  <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            low_q   <= low_d;
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
            rem_q   <= rem_d;
`endif
            result  <= result_d;
            ready   <= (state_d == IDLE);
            done    <= (state_d == DONE);
            illegal <= illegal_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32); divide tests follow MULDIV_DIV_EN like the design.
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic            ready, done, illegal;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference model built on native 64-bit arithmetic; lat counts edges from the start edge
    function automatic exp_t make_exp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, sp;
        logic [63:0] up;
`ifdef MULDIV_DIV_EN
        logic signed [31:0] xs, ys;
        logic ovf;
`endif
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        e.res = 32'd0;
        e.ill = 1'b0;
        e.lat = 33;
        if (o[2]) begin
`ifdef MULDIV_DIV_EN
            xs  = x;
            ys  = y;
            ovf = !o[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
            if (y == 32'd0) begin
                e.lat = 1;
                e.res = o[1] ? x : 32'hFFFF_FFFF;
            end else if (ovf) begin
                e.lat = 1;
                e.res = o[1] ? 32'd0 : x;
            end else begin
                case (o[1:0])
                    2'd0:    e.res = xs / ys;
                    2'd1:    e.res = x / y;
                    2'd2:    e.res = xs % ys;
                    default: e.res = x % y;
                endcase
            end
`else
            e.lat = 1;
            e.ill = 1'b1;
`endif
        end else begin
            case (o[1:0])
                2'd0: begin up = {32'd0, x} * {32'd0, y}; e.res = up[31:0]; end
                2'd1: begin sp = sx * sy; e.res = sp[63:32]; end
                2'd2: begin sp = sx * $signed({32'd0, y}); e.res = sp[63:32]; end
                default: begin up = {32'd0, x} * {32'd0, y}; e.res = up[63:32]; end
            endcase
        end
        return e;
    endfunction

    // Drive one start pulse (at a negedge) and record its expectation
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; lat=1 means done seen right after the start edge
    task automatic wait_done(output int lat, output logic [31:0] res, output logic ill);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        ill = illegal;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b expected 0", illegal); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h expected 0", result); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4];
        logic [31:0] t_b [4];
        logic [31:0] t_r [4];
        exp_t e;
        int lat;
        logic [31:0] res, x, y;
        logic ill;
        logic [2:0] o;
        t_op = '{3'd0, 3'd1, 3'd2, 3'd3};
        t_a  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_b  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_r  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                o = t_op[i]; x = t_a[i]; y = t_b[i];
                e.res = t_r[i]; e.lat = 33; e.ill = 1'b0;
            end else begin
                o = 3'($urandom_range(0, 3)); x = $urandom; y = $urandom;
                e = make_exp(o, x, y);
            end
            launch(o, x, y, e);
            wait_done(lat, res, ill);
            e = exp_q.pop_front();
            checks++; if (res !== e.res) begin errors++; $display("FAIL mul[%0d] op=%0d result got %h expected %h", i, o, res, e.res); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL mul[%0d] latency got %0d expected %0d", i, lat, e.lat); end
            checks++; if (ill !== e.ill) begin errors++; $display("FAIL mul[%0d] illegal got %b expected %b", i, ill, e.ill); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL mul[%0d] pulse done=%b ready=%b expected 0/1", i, done, ready); end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4];
        logic [31:0] t_b [4];
        logic [31:0] t_r [4];
        exp_t e;
        int lat;
        logic [31:0] res, x, y;
        logic ill;
        logic [2:0] o;
        t_op = '{3'd4, 3'd6, 3'd5, 3'd7};
        t_a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        t_b  = '{32'd2, 32'd2, 32'd7, 32'd7};
        t_r  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                o = t_op[i]; x = t_a[i]; y = t_b[i];
                e.res = t_r[i]; e.lat = 33; e.ill = 1'b0;
            end else begin
                o = 3'(4 + $urandom_range(0, 3)); x = $urandom;
                y = (i % 2 == 1) ? $urandom : 32'($urandom_range(1, 1000));
                e = make_exp(o, x, y);
            end
            launch(o, x, y, e);
            wait_done(lat, res, ill);
            e = exp_q.pop_front();
            checks++; if (res !== e.res) begin errors++; $display("FAIL div[%0d] op=%0d result got %h expected %h", i, o, res, e.res); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL div[%0d] latency got %0d expected %0d", i, lat, e.lat); end
            checks++; if (ill !== e.ill) begin errors++; $display("FAIL div[%0d] illegal got %b expected %b", i, ill, e.ill); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL div[%0d] pulse done=%b ready=%b expected 0/1", i, done, ready); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4];
        logic [31:0] t_b [4];
        logic [31:0] t_r [4];
        exp_t e;
        int lat;
        logic [31:0] res;
        logic ill;
        t_op = '{3'd4, 3'd7, 3'd4, 3'd6};
        t_a  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        t_b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_r  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            e.res = t_r[i]; e.lat = 1; e.ill = 1'b0;
            launch(t_op[i], t_a[i], t_b[i], e);
            wait_done(lat, res, ill);
            e = exp_q.pop_front();
            checks++; if (res !== e.res) begin errors++; $display("FAIL special[%0d] result got %h expected %h", i, res, e.res); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL special[%0d] latency got %0d expected %0d", i, lat, e.lat); end
            checks++; if (ill !== e.ill) begin errors++; $display("FAIL special[%0d] illegal got %b expected %b", i, ill, e.ill); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL special[%0d] pulse done=%b ready=%b expected 0/1", i, done, ready); end
        end
    endtask
`else
    task automatic test_illegal();
        exp_t e;
        int lat;
        logic [31:0] res;
        logic ill;
        e.res = 32'd0; e.lat = 1; e.ill = 1'b1;
        launch(3'd5, 32'd9, 32'd3, e);
        wait_done(lat, res, ill);
        e = exp_q.pop_front();
        checks++; if (res !== e.res) begin errors++; $display("FAIL illegal_divu result got %h expected %h", res, e.res); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL illegal_divu latency got %0d expected %0d", lat, e.lat); end
        checks++; if (ill !== e.ill) begin errors++; $display("FAIL illegal_divu flag got %b expected %b", ill, e.ill); end
        @(negedge clk);
        checks++; if (illegal !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL illegal_pulse illegal=%b done=%b expected 0/0", illegal, done); end
        e.res = 32'd42; e.lat = 33; e.ill = 1'b0;
        launch(3'd0, 32'd6, 32'd7, e);
        wait_done(lat, res, ill);
        e = exp_q.pop_front();
        checks++; if (res !== e.res) begin errors++; $display("FAIL illegal_then_mul result got %h expected %h", res, e.res); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL illegal_then_mul latency got %0d expected %0d", lat, e.lat); end
        checks++; if (ill !== e.ill) begin errors++; $display("FAIL illegal_then_mul flag got %b expected %b", ill, e.ill); end
        @(negedge clk);
    endtask
`endif

    task automatic test_ignore_start();
        exp_t e;
        int lat;
        e.res = 32'd15; e.lat = 33; e.ill = 1'b0;
        launch(3'd0, 32'd3, 32'd5, e);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == 5) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ignore_busy ready got %b expected 0", ready); end
                start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            end
            if (lat == 7) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        checks++; if (result !== e.res) begin errors++; $display("FAIL ignore_result got %h expected %h", result, e.res); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL ignore_latency got %0d expected %0d", lat, e.lat); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        exp_t e;
        logic seen;
        e.res = 32'd20000; e.lat = 33; e.ill = 1'b0;
        launch(3'd0, 32'd100, 32'd200, e);
        void'(exp_q.pop_front());
        repeat (9) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL abort_result got %h expected 0", result); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got done pulse=%b expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        logic [31:0] res;
        logic ill;
        e.res = 32'hFFFF_FFEB; e.lat = 33; e.ill = 1'b0;
        launch(3'd0, 32'hFFFF_FFFD, 32'd7, e);
        wait_done(lat, res, ill);
        e = exp_q.pop_front();
        checks++; if (res !== e.res) begin errors++; $display("FAIL b2b_first result got %h expected %h", res, e.res); end
        start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        e.res = 32'hFFFF_FFFE; e.lat = 33; e.ill = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b expected 1", ready); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept ready got %b expected 0", ready); end
        wait_done(lat, res, ill);
        e = exp_q.pop_front();
        checks++; if (res !== e.res) begin errors++; $display("FAIL b2b_second result got %h expected %h", res, e.res); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_second latency got %0d expected %0d", lat, e.lat); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        test_reset();
        test_mul();
`ifdef MULDIV_DIV_EN
        test_div();
        test_special();
`else
        test_illegal();
`endif
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 8..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only when ready=1.
REQ-005 The block SHALL have port op, input, 3 bits: RV32M funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports a and b, input, XLEN bits each: rs1 and rs2 operands.
REQ-007 The block SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, XLEN bits: registered result, held until the next accepted start.
REQ-010 The block SHALL have port illegal, output, 1 bit: pulses with done when the op is not compiled in.

Function
REQ-011 The block SHALL use FSM states IDLE, CALC and DONE. IDLE goes to CALC on start (or to DONE for a special case). CALC goes to DONE when the step counter reaches XLEN. DONE goes to IDLE unconditionally.
REQ-012 The block SHALL latch op, a and b on an accepted start; later input changes SHALL NOT affect the operation in flight.
REQ-013 The block SHALL ignore start while ready=0, with no queuing and no error.
REQ-014 The block SHALL process one bit per CALC cycle, using shift-add for multiply and restoring shift-subtract for divide, with a counter of width clog2(XLEN+1).
REQ-015 Normal latency SHALL be fixed: start accepted at edge N puts done high in cycle N+XLEN+1 and ready high again in cycle N+XLEN+2.
REQ-016 Signed ops SHALL work on operand magnitudes and apply the sign correction in DONE.
  - MULH and DIV/REM: a and b are signed.
  - MULHSU: a is signed, b is unsigned.
  - Product sign is sign(a) XOR sign(b).
  - Remainder sign follows the dividend.
REQ-017 Multiply SHALL form a 2*XLEN product. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
REQ-018 Division by zero SHALL bypass CALC with done one cycle after start. DIV/DIVU return all ones; REM/REMU return a.
REQ-019 Signed overflow (a = -2^(XLEN-1), b = -1) SHALL bypass CALC with done one cycle after start. DIV returns a; REM returns 0.
REQ-020 done SHALL be high only in DONE. result SHALL update on the edge entering DONE and SHALL be stable while done=1.

Reset
REQ-021 When reset=1 at a rising edge, the block SHALL enter IDLE and clear the counter and working registers.
REQ-022 During reset the outputs SHALL be ready=1, done=0, illegal=0, result=0.
REQ-023 Reset mid-CALC or mid-DONE SHALL abort the operation; no done pulse is produced for it.
REQ-024 reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro MULDIV_DIV_EN defined: divide/remainder ops (op[2]=1) SHALL be implemented per REQ-014 to REQ-019.
REQ-026 Macro MULDIV_DIV_EN undefined: no divider logic SHALL be built. An op[2]=1 start SHALL go IDLE to DONE with done one cycle after start, result=0 and illegal=1. Multiply behaviour SHALL be unchanged.

Verification
REQ-027 Bench SHALL cover signed multiply, XLEN=32: MUL a=-3, b=7 gives result 0xFFFFFFEB with done exactly 33 cycles after the start edge. MULH 0x80000000 * 0x80000000 gives 0x40000000.
REQ-028 Bench SHALL cover MULHSU a=-1, b=0xFFFFFFFF giving 0xFFFFFFFF, and MULHU with the same operands giving 0xFFFFFFFE.
REQ-029 Bench SHALL cover division: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100/7 gives 2.
REQ-030 Bench SHALL cover special cases, each with done one cycle after start:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/-1 gives 0x80000000.
  - REM with the same operands gives 0.
REQ-031 Bench SHALL cover control corner cases:
  - A start pulse mid-CALC is ignored and result equals the first op.
  - Reset asserted at CALC cycle 10 gives no done pulse and ready=1 the cycle after.
  - Back-to-back starts: the second start is accepted in the first cycle ready=1.
REQ-032 Bench SHALL cover the build without MULDIV_DIV_EN: DIVU 9/3 gives done plus illegal after 1 cycle with result 0, and a following MUL 6*7 gives 42.
